dcache_axi_ctrl: RTL and testbench
==================================

DCACHE_AXI_CTRL -- requirements
Module: dcache_axi_ctrl

Interface
REQ-001 SHALL have parameter SETS, default 64, number of cache sets; power of two, at least 2.
REQ-002 SHALL have parameter BEATS, default 4, AXI data beats per line; power of two, at least 2.
REQ-003 SHALL have port clk  in  1  clock; all state on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cpu_valid in 1, cpu_flush in 1, cpu_ready out 1  CPU request handshake; cpu_flush is qualified by cpu_valid.
REQ-006 SHALL have ports rsp_valid out 1, rsp_ready in 1  CPU completion handshake.
REQ-007 SHALL have ports hit in 1, line_valid in 1, line_dirty in 1  status of the addressed line (LOOKUP) or of the line at set_idx (FL_SCAN).
REQ-008 SHALL have ports lookup_en out 1 (capture request), hit_access out 1 (array read/write), fill_we out 1 (write one beat), tag_we out 1 (write tag, set valid, clear dirty).
REQ-009 SHALL have ports beat_idx out log2(BEATS), set_idx out log2(SETS), flushing out 1.
REQ-010 SHALL have AXI ports arvalid out, arready in, rvalid in, rready out, rlast in, awvalid out, awready in, wvalid out, wready in, wlast out, bvalid in, bready out; all 1 bit.

Function
REQ-011 SHALL implement the states IDLE, LOOKUP, WB_AW, WB_W, WB_B, RF_AR, RF_R, RESP, FL_SCAN, plus a registered mode bit: 0 = miss, 1 = flush.
REQ-012 IDLE: cpu_ready=1 and no other output asserted. On cpu_valid&cpu_flush: go to FL_SCAN, set_idx<=0, mode<=1. Else on cpu_valid: go to LOOKUP, lookup_en=1 for one cycle, mode<=0. Flush has priority.
REQ-013 cpu_ready SHALL be 0 in every state except IDLE.
REQ-014 LOOKUP, takes 1 cycle:
- hit: hit_access=1 for exactly one cycle, then RESP.
- miss with line_valid&line_dirty: WB_AW.
- any other miss: RF_AR.
REQ-015 WB_AW: awvalid=1 until awready is sampled high, then WB_W with beat_idx=0.
REQ-016 WB_W: wvalid=1. Each wvalid&wready increments beat_idx. wlast=1 exactly when beat_idx==BEATS-1. After the last beat: WB_B.
REQ-017 WB_B: bready=1. On bvalid:
- mode 0: go to RF_AR.
- mode 1: tag_we=1, then RESP if set_idx==SETS-1; otherwise set_idx+1 and FL_SCAN.
REQ-018 RF_AR: arvalid=1 until arready, then RF_R with beat_idx=0.
REQ-019 RF_R: rready=1. Each rvalid gives fill_we=1 and beat_idx+1. On beat BEATS-1: tag_we=1 in the same cycle, then LOOKUP (replay; this lookup hits).
REQ-020 rlast SHALL be ignored; the beat counter alone ends the burst.
REQ-021 FL_SCAN: flushing=1, one set per cycle.
- line_valid&line_dirty: go to WB_AW.
- otherwise, set_idx==SETS-1: go to RESP.
- otherwise: set_idx+1 and stay.
REQ-022 flushing SHALL stay 1 in WB_AW, WB_W and WB_B while mode=1, and SHALL be 0 in all other states.
REQ-023 RESP: rsp_valid=1 until rsp_ready, then IDLE.
REQ-024 Every AXI valid SHALL stay high and stable until its handshake completes, and SHALL NOT depend combinationally on its ready.
REQ-025 beat_idx SHALL wrap to 0 after BEATS-1. set_idx SHALL never pass SETS-1.
REQ-026 All outputs SHALL be decoded from state and registers only, except: hit_access (from hit), fill_we (from rvalid), tag_we, lookup_en.

Reset
REQ-027 With rst low, the block SHALL be in IDLE with cpu_ready=1, every other output 0, beat_idx=0, set_idx=0, mode=0.
REQ-028 Reset asserted mid-burst SHALL deassert all AXI valids asynchronously. No partial fill or writeback is resumed.

Verification
REQ-029 Hit: cpu_valid with hit=1 -> LOOKUP 1 cycle, hit_access 1 cycle; rsp_valid held 3 cycles while rsp_ready=0, then IDLE.
REQ-030 Clean miss, BEATS=4, arready delayed 2 cycles -> arvalid held 3 cycles; 4 fill_we pulses with beat_idx 0..3; tag_we on beat 3; replay hit; rsp_valid.
REQ-031 Dirty miss with wready toggling -> AW, then 4 W beats with wlast only on beat 3, then B, then AR refill. No AR is issued before bvalid.
REQ-032 Flush, SETS=4, only set 2 dirty -> sets 0,1 scanned in 2 cycles; writeback of set 2; tag_we; set 3 scanned; RESP. flushing high from FL_SCAN entry until RESP.
REQ-033 cpu_valid&cpu_flush together in IDLE -> FL_SCAN taken, lookup_en stays 0.
REQ-034 rst pulsed low during RF_R beat 2 -> rready, arvalid and fill_we go to 0 immediately; after release, cpu_ready=1 and beat_idx=0.

Source files
------------

// File: rtl/dcache_axi_ctrl.sv
// Data-cache miss/flush controller.
// Sequences CPU lookups, dirty-line writebacks and line refills over an AXI
// master port, and walks every set to write back dirty lines on a flush.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a CPU request
// LOOKUP  | tag compare on the captured (or replayed) request
// WB_AW   | writeback address phase
// WB_W    | writeback data beats, beat_idx counts
// WB_B    | waiting for the writeback response
// RF_AR   | refill address phase
// RF_R    | refill data beats, one array write per beat
// RESP    | completion handshake towards the CPU
// FL_SCAN | flush walk, one set per cycle at set_idx
module dcache_axi_ctrl #(
  parameter int SETS  = 64,
  parameter int BEATS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  // CPU request / completion
  input  logic                     cpu_valid,
  input  logic                     cpu_flush,
  output logic                     cpu_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  // line status from the tag array
  input  logic                     hit,
  input  logic                     line_valid,
  input  logic                     line_dirty,
  // array control
  output logic                     lookup_en,
  output logic                     hit_access,
  output logic                     fill_we,
  output logic                     tag_we,
  output logic [$clog2(BEATS)-1:0] beat_idx,
  output logic [$clog2(SETS)-1:0]  set_idx,
  output logic                     flushing,
  // AXI master
  output logic                     arvalid,
  input  logic                     arready,
  input  logic                     rvalid,
  output logic                     rready,
  input  logic                     rlast,
  output logic                     awvalid,
  input  logic                     awready,
  output logic                     wvalid,
  input  logic                     wready,
  output logic                     wlast,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int BW = $clog2(BEATS);
  localparam int SW = $clog2(SETS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [SW-1:0] LAST_SET  = SW'(SETS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_AW,
    S_WB_W,
    S_WB_B,
    S_RF_AR,
    S_RF_R,
    S_RESP,
    S_FL_SCAN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_mode;       // 0: serving a miss, 1: flush walk
  logic          w_mode_nxt;
  logic [BW-1:0] r_beat;
  logic [BW-1:0] w_beat_nxt;
  logic [BW-1:0] w_beat_inc;
  logic [SW-1:0] r_set;
  logic [SW-1:0] w_set_nxt;
  logic [SW-1:0] w_set_inc;
  logic          w_beat_last;
  logic          w_set_last;

  // The burst is terminated by this counter alone; rlast is deliberately
  // unused so a misbehaving slave cannot cut a refill short.
  logic w_unused;
  assign w_unused = rlast;

  assign w_beat_inc  = r_beat + BW'(1);
  assign w_set_inc   = r_set + SW'(1);
  assign w_beat_last = (r_beat == LAST_BEAT);
  assign w_set_last  = (r_set == LAST_SET);

  assign beat_idx = r_beat;
  assign set_idx  = r_set;

  // State and index registers; reset drops every AXI valid immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_beat  <= '0;
      r_set   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_beat  <= w_beat_nxt;
      r_set   <= w_set_nxt;
    end
  end

  // Next-state, index updates and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_beat_nxt  = r_beat;
    w_set_nxt   = r_set;
    cpu_ready   = 1'b0;
    rsp_valid   = 1'b0;
    lookup_en   = 1'b0;
    hit_access  = 1'b0;
    fill_we     = 1'b0;
    tag_we      = 1'b0;
    flushing    = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    wlast       = 1'b0;
    bready      = 1'b0;

    case (r_state)
      S_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_valid) begin
          if (cpu_flush) begin
            w_state_nxt = S_FL_SCAN;
            w_set_nxt   = '0;
            w_mode_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_LOOKUP;
            lookup_en   = 1'b1;
            w_mode_nxt  = 1'b0;
          end
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          hit_access  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (line_valid && line_dirty) begin
          w_state_nxt = S_WB_AW;
        end else begin
          w_state_nxt = S_RF_AR;
        end
      end

      S_WB_AW: begin
        awvalid = 1'b1;
        if (awready) begin
          w_state_nxt = S_WB_W;
          w_beat_nxt  = '0;
        end
      end

      S_WB_W: begin
        wvalid = 1'b1;
        wlast  = w_beat_last;
        if (wready) begin
          w_beat_nxt = w_beat_inc;
          if (w_beat_last) begin
            w_state_nxt = S_WB_B;
          end
        end
      end

      S_WB_B: begin
        bready = 1'b1;
        if (bvalid) begin
          if (!r_mode) begin
            w_state_nxt = S_RF_AR;
          end else begin
            // flushed line is now clean; rewrite its tag before moving on
            tag_we = 1'b1;
            if (w_set_last) begin
              w_state_nxt = S_RESP;
            end else begin
              w_set_nxt   = w_set_inc;
              w_state_nxt = S_FL_SCAN;
            end
          end
        end
      end

      S_RF_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          w_state_nxt = S_RF_R;
          w_beat_nxt  = '0;
        end
      end

      S_RF_R: begin
        rready = 1'b1;
        if (rvalid) begin
          fill_we    = 1'b1;
          w_beat_nxt = w_beat_inc;
          if (w_beat_last) begin
            // tag written with the final beat so the replayed lookup hits
            tag_we      = 1'b1;
            w_state_nxt = S_LOOKUP;
          end
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
          w_set_nxt   = '0;
        end
      end

      S_FL_SCAN: begin
        if (line_valid && line_dirty) begin
          w_state_nxt = S_WB_AW;
        end else if (w_set_last) begin
          w_state_nxt = S_RESP;
        end else begin
          w_set_nxt = w_set_inc;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    flushing = (r_state == S_FL_SCAN) ||
               (r_mode && ((r_state == S_WB_AW) || (r_state == S_WB_W) ||
                           (r_state == S_WB_B)));
  end

endmodule

// File: tb/tb_dcache_axi_ctrl.sv
// Bench for dcache_axi_ctrl: directed scenarios push the expected observable
// events into a queue; a monitor pops and compares as the DUT produces them.
module tb_dcache_axi_ctrl;

  localparam int SETS  = 4;
  localparam int BEATS = 4;

  localparam logic [3:0] K_LK   = 4'd1;
  localparam logic [3:0] K_HA   = 4'd2;
  localparam logic [3:0] K_AR   = 4'd3;
  localparam logic [3:0] K_R    = 4'd4;
  localparam logic [3:0] K_AW   = 4'd5;
  localparam logic [3:0] K_W    = 4'd6;
  localparam logic [3:0] K_B    = 4'd7;
  localparam logic [3:0] K_RSP  = 4'd8;
  localparam logic [3:0] K_SCAN = 4'd9;

  logic clk;
  logic rst;
  logic cpu_valid, cpu_flush, cpu_ready;
  logic rsp_valid, rsp_ready;
  logic hit, line_valid, line_dirty;
  logic lookup_en, hit_access, fill_we, tag_we, flushing;
  logic [1:0] beat_idx;
  logic [1:0] set_idx;
  logic arvalid, arready, rvalid, rready, rlast;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;

  // cache-array model
  logic       tb_hit, tb_lv, tb_ld;
  logic [3:0] fl_valid, fl_dirty;
  logic       seen_fill;

  logic [11:0] q[$];
  int vectors;
  int miscompares;

  dcache_axi_ctrl #(.SETS(SETS), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_flush(cpu_flush), .cpu_ready(cpu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .hit(hit), .line_valid(line_valid), .line_dirty(line_dirty),
    .lookup_en(lookup_en), .hit_access(hit_access), .fill_we(fill_we),
    .tag_we(tag_we), .beat_idx(beat_idx), .set_idx(set_idx),
    .flushing(flushing),
    .arvalid(arvalid), .arready(arready), .rvalid(rvalid), .rready(rready),
    .rlast(rlast), .awvalid(awvalid), .awready(awready), .wvalid(wvalid),
    .wready(wready), .wlast(wlast), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A refilled line hits on the replayed lookup until a new request arrives.
  always @(posedge clk or negedge rst) begin
    if (!rst)           seen_fill <= 1'b0;
    else if (lookup_en) seen_fill <= 1'b0;
    else if (tag_we)    seen_fill <= 1'b1;
  end

  assign hit        = tb_hit | seen_fill;
  assign line_valid = flushing ? fl_valid[set_idx] : tb_lv;
  assign line_dirty = flushing ? fl_dirty[set_idx] : tb_ld;

  function automatic logic [11:0] ev(logic [3:0] k, logic [7:0] d);
    return {k, d};
  endfunction

  task automatic exp_ev(logic [3:0] k, logic [7:0] d);
    q.push_back(ev(k, d));
  endtask

  task automatic chk(string name, int act, int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_loop();
    logic [11:0] e;
    logic        got;
    forever begin
      @(negedge clk);
      if (rst) begin
        got = 1'b1;
        if (lookup_en)                e = ev(K_LK, 8'h00);
        else if (hit_access)          e = ev(K_HA, 8'h00);
        else if (arvalid && arready)  e = ev(K_AR, 8'h00);
        else if (fill_we)             e = ev(K_R, {tag_we, 5'b0, beat_idx});
        else if (awvalid && awready)  e = ev(K_AW, 8'h00);
        else if (wvalid && wready)    e = ev(K_W, {wlast, 5'b0, beat_idx});
        else if (bready && bvalid)    e = ev(K_B, {tag_we, 5'b0, set_idx});
        else if (rsp_valid && rsp_ready) e = ev(K_RSP, 8'h00);
        else if (flushing && !awvalid && !wvalid && !bready)
                                      e = ev(K_SCAN, {6'b0, set_idx});
        else got = 1'b0;
        if (got) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got 0x%03h, expected none at %0t", e, $time);
          end else begin
            chk("event", int'(e), int'(q.pop_front()));
          end
        end
      end
    end
  endtask

  task automatic req(logic f);
    cpu_valid = 1'b1;
    cpu_flush = f;
    tick();
    cpu_valid = 1'b0;
    cpu_flush = 1'b0;
  endtask

  task automatic wait_rsp(string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk(name, int'(rsp_valid), 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({name, "_idle"}, int'(cpu_ready), 1);
  endtask

  task automatic refill_beats();
    for (int b = 0; b < BEATS; b++) begin
      rvalid = 1'b1;
      tick();
    end
    rvalid = 1'b0;
  endtask

  initial begin
    int cnt;
    int n;
    int bad;
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    {cpu_valid, cpu_flush, rsp_ready} = '0;
    {arready, rvalid, rlast, awready, wready, bvalid} = '0;
    {tb_hit, tb_lv, tb_ld} = '0;
    fl_valid = '0;
    fl_dirty = '0;
    fork
      mon_loop();
    join_none

    // reset state
    #1;
    chk("rst_cpu_ready", int'(cpu_ready), 1);
    chk("rst_outputs", int'({rsp_valid, lookup_en, hit_access, fill_we, tag_we,
                             flushing, arvalid, rready, awvalid, wvalid, wlast,
                             bready, beat_idx, set_idx}), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // hit, response stalled three cycles
    tb_hit = 1'b1;
    exp_ev(K_LK, 8'h00); exp_ev(K_HA, 8'h00); exp_ev(K_RSP, 8'h00);
    req(1'b0);
    chk("hit_busy", int'(cpu_ready), 0);
    tick();
    cnt = 0;
    repeat (3) begin
      if (rsp_valid) cnt++;
      tick();
    end
    chk("hit_rsp_hold", cnt, 3);
    wait_rsp("hit_rsp");
    tb_hit = 1'b0;

    // clean miss, arready two cycles late, gap in R, stray rlast
    tb_lv = 1'b1;
    tb_ld = 1'b0;
    exp_ev(K_LK, 8'h00); exp_ev(K_AR, 8'h00);
    exp_ev(K_R, 8'h00); exp_ev(K_R, 8'h01); exp_ev(K_R, 8'h02); exp_ev(K_R, 8'h83);
    exp_ev(K_HA, 8'h00); exp_ev(K_RSP, 8'h00);
    req(1'b0);
    tick();
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      if (arvalid) cnt++;
      tick();
    end
    arready = 1'b1;
    if (arvalid) cnt++;
    tick();
    arready = 1'b0;
    chk("clean_ar_hold", cnt, 3);
    chk("clean_ar_done", int'(arvalid), 0);
    for (int b = 0; b < BEATS; b++) begin
      rvalid = 1'b1;
      rlast = (b == 1);
      tick();
      rvalid = 1'b0;
      rlast = 1'b0;
      if (b == 1) tick();
    end
    wait_rsp("clean_rsp");

    // dirty miss, wready toggling, late bvalid
    tb_ld = 1'b1;
    exp_ev(K_LK, 8'h00); exp_ev(K_AW, 8'h00);
    exp_ev(K_W, 8'h00); exp_ev(K_W, 8'h01); exp_ev(K_W, 8'h02); exp_ev(K_W, 8'h83);
    exp_ev(K_B, 8'h00); exp_ev(K_AR, 8'h00);
    exp_ev(K_R, 8'h00); exp_ev(K_R, 8'h01); exp_ev(K_R, 8'h02); exp_ev(K_R, 8'h83);
    exp_ev(K_HA, 8'h00); exp_ev(K_RSP, 8'h00);
    req(1'b0);
    tick();
    chk("dirty_aw", int'(awvalid), 1);
    bad = 0;
    tick();
    awready = 1'b1;
    tick();
    awready = 1'b0;
    n = 0;
    while (!bready && n < 40) begin
      wready = n[0];
      if (arvalid) bad++;
      tick();
      n++;
    end
    wready = 1'b0;
    chk("dirty_b_reached", int'(bready), 1);
    if (arvalid) bad++;
    tick();
    if (arvalid) bad++;
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("dirty_no_early_ar", bad, 0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    refill_beats();
    wait_rsp("dirty_rsp");
    tb_lv = 1'b0;
    tb_ld = 1'b0;

    // flush, only set 2 dirty
    fl_valid = 4'b1111;
    fl_dirty = 4'b0100;
    exp_ev(K_SCAN, 8'h00); exp_ev(K_SCAN, 8'h01); exp_ev(K_SCAN, 8'h02);
    exp_ev(K_AW, 8'h00);
    exp_ev(K_W, 8'h00); exp_ev(K_W, 8'h01); exp_ev(K_W, 8'h02); exp_ev(K_W, 8'h83);
    exp_ev(K_B, 8'h82); exp_ev(K_SCAN, 8'h03); exp_ev(K_RSP, 8'h00);
    cpu_valid = 1'b1;
    cpu_flush = 1'b1;
    #1;
    chk("flush_no_lookup_en", int'(lookup_en), 0);
    tick();
    cpu_valid = 1'b0;
    cpu_flush = 1'b0;
    bad = 0;
    n = 0;
    while (!awvalid && n < 20) begin
      if (!flushing) bad++;
      tick();
      n++;
    end
    chk("flush_aw_reached", int'(awvalid), 1);
    awready = 1'b1;
    if (!flushing) bad++;
    tick();
    awready = 1'b0;
    wready = 1'b1;
    n = 0;
    while (!bready && n < 20) begin
      if (!flushing) bad++;
      tick();
      n++;
    end
    wready = 1'b0;
    bvalid = 1'b1;
    if (!flushing) bad++;
    tick();
    bvalid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (!flushing) bad++;
      tick();
      n++;
    end
    chk("flush_flushing_held", bad, 0);
    chk("flush_resp_flushing", int'(flushing), 0);
    wait_rsp("flush_rsp");
    fl_valid = '0;
    fl_dirty = '0;

    // reset in the middle of a refill, at beat 2
    exp_ev(K_LK, 8'h00); exp_ev(K_AR, 8'h00);
    exp_ev(K_R, 8'h00); exp_ev(K_R, 8'h01);
    req(1'b0);
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1;
    tick();
    tick();
    chk("rst_mid_beat", int'(beat_idx), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_rready", int'(rready), 0);
    chk("rst_mid_arvalid", int'(arvalid), 0);
    chk("rst_mid_fill_we", int'(fill_we), 0);
    rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_rel_cpu_ready", int'(cpu_ready), 1);
    chk("rst_rel_beat", int'(beat_idx), 0);
    tick();
    tick();
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
